// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with load-use hazard detection.
//
// Sits directly behind the decode-stage register file and main control unit.
// Each cycle it either captures the decode instruction for EXECUTE or loads a
// bubble (on flush or load-use hazard). A saturating counter tracks the number
// of stall cycles since reset.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   flush                 kill the instruction entering EX this cycle
//   id_valid .. id_ex     decode-stage instruction fields and control bundles
//   stall                 combinational; hold PC and IF/ID this cycle
//   ex_valid .. ex_ex     latched fields for the EXECUTE stage
//   stall_cnt             saturating count of cycles with stall=1
module id_ex_pipe #(
  parameter int DW   = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [DW-1:0]   id_npc,
  input  logic [DW-1:0]   id_a,
  input  logic [DW-1:0]   id_b,
  input  logic [15:0]     id_imm,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      id_rt,
  input  logic [4:0]      id_rd,
  input  logic [1:0]      id_wb,
  input  logic [2:0]      id_m,
  input  logic [3:0]      id_ex,
  output logic            stall,
  output logic            ex_valid,
  output logic [DW-1:0]   ex_npc,
  output logic [DW-1:0]   ex_a,
  output logic [DW-1:0]   ex_b,
  output logic [DW-1:0]   ex_imm,
  output logic [4:0]      ex_rs,
  output logic [4:0]      ex_rt,
  output logic [4:0]      ex_rd,
  output logic [1:0]      ex_wb,
  output logic [2:0]      ex_m,
  output logic [3:0]      ex_ex,
  output logic [CNTW-1:0] stall_cnt
);

  logic hazard;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    if (&v) return v;
    return v + {{(CNTW-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic signed [DW-1:0] sext_imm(input logic signed [15:0] v);
    return {{(DW-16){v[15]}}, v};
  endfunction

  // Load in EX whose destination (rt) feeds the decode instruction. $0 never
  // carries a real dependency, so it is excluded.
  always_comb begin
    hazard = ex_valid & ex_m[1] & id_valid & (ex_rt != 5'd0) &
             ((ex_rt == id_rs) | (ex_rt == id_rt));
    stall  = hazard & ~flush;
  end

  // ---- ID -> EX stage boundary ----
  // Flush and hazard both load an all-zero bubble; when both are present the
  // flush dominates only in that stall stays low (see the stall equation).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_npc   <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_imm   <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
      ex_wb    <= '0;
      ex_m     <= '0;
      ex_ex    <= '0;
    end else if (flush | hazard) begin
      ex_valid <= 1'b0;
      ex_npc   <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_imm   <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
      ex_wb    <= '0;
      ex_m     <= '0;
      ex_ex    <= '0;
    end else begin
      ex_valid <= id_valid;
      ex_npc   <= id_npc;
      ex_a     <= id_a;
      ex_b     <= id_b;
      ex_imm   <= sext_imm(id_imm);
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_rd    <= id_rd;
      ex_wb    <= id_wb;
      ex_m     <= id_m;
      ex_ex    <= id_ex;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     stall_cnt <= '0;
    else if (stall) stall_cnt <= sat_inc(stall_cnt);
  end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- ID/EX pipeline register directly downstream of the DECODE-stage register file (REG) and the main control unit.
- Latches A/B read data, the sign-extended immediate, register specifiers and control bundles for the EXECUTE stage.
- Contains the load-use hazard detector: raises a stall to PC/IF-ID and inserts a bubble into EX.
- Honours a flush from branch resolution and keeps a saturating stall-cycle counter for performance checks.

Parameters:
- DW, 32, datapath width for A, B, NPC and the extended immediate.
- CNTW, 16, width of the stall counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  kill the instruction entering EX this cycle (bubble)
- id_valid  input  1  decode stage holds a real instruction
- id_npc  input  DW  PC+4 of the decode instruction
- id_a  input  DW  REG read port A (rs)
- id_b  input  DW  REG read port B (rt)
- id_imm  input  16  instruction[15:0]
- id_rs  input  5  rs specifier
- id_rt  input  5  rt specifier
- id_rd  input  5  rd specifier
- id_wb  input  2  {regwrite, memtoreg}
- id_m  input  3  {branch, memread, memwrite}
- id_ex  input  4  {regdst, aluop[1:0], alusrc}
- stall  output  1  combinational; hold PC and IF/ID this cycle
- ex_valid  output  1  EX holds a real instruction
- ex_npc, ex_a, ex_b, ex_imm  output  DW each  latched NPC, A, B, sign-extended immediate
- ex_rs, ex_rt, ex_rd  output  5 each  latched specifiers
- ex_wb  output  2  latched WB controls
- ex_m  output  3  latched M controls
- ex_ex  output  4  latched EX controls
- stall_cnt  output  CNTW  number of cycles with stall=1 since reset

Behaviour:
- Reset (rst_n=0, asynchronous): every ex_* output = 0, ex_valid = 0, stall_cnt = 0. stall then evaluates to 0 because ex_m[1]=0.
- hazard = ex_valid & ex_m[1] (memread) & id_valid & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
- stall = hazard & ~flush. It is purely combinational from the registered ex_* state and the current id_* inputs.
- Each rising clk, priority order:
  1. flush=1: load a bubble.
  2. hazard=1: load a bubble. Upstream holds, so the same decode instruction is re-presented next cycle.
  3. Otherwise: capture all id_* fields and set ex_valid = id_valid.
- Bubble: ex_valid, ex_wb, ex_m and ex_ex = 0; all data and specifier outputs = 0. A bubble never writes a register or memory.
- Latency: one cycle, id_* to ex_*.
- A load-use stall always lasts exactly one cycle: the bubble clears memread, so hazard drops on the next cycle.
- ex_imm = {{(DW-16){id_imm[15]}}, id_imm}, sign-extended with no zero-extend mode.
- An id_valid=0 input with no flush and no hazard is captured as-is with ex_valid=0. Its control fields are passed through unchanged; upstream guarantees they are 0.
- stall_cnt increments by 1 on each clock edge where stall=1. It saturates at all-ones and never wraps.
- flush and hazard in the same cycle: flush wins, stall=0, the counter does not increment, and the bubble is loaded.
- Register $0: ex_rt=0 with memread never stalls.
- Reset asserted mid-stall: outputs clear immediately and stall drops the same cycle.
- No X propagation: every register has an explicit reset value.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with nonzero id_* inputs -> all ex_* = 0, stall = 0 and stall_cnt = 0 immediately, with no clock edge needed.
- Pass-through: id_a=32'h002300AA, id_b=32'h10654321, id_imm=16'h8001, id_rt=5'd3, id_wb=2'b10 -> one edge later ex_a=32'h002300AA, ex_b=32'h10654321, ex_imm=32'hFFFF8001, ex_rt=3, ex_wb=2'b10, ex_valid=1.
- Load-use: an lw with ex_rt=5'd8 and ex_m=3'b010 is in EX; decode presents id_rs=5'd8 -> stall=1 for exactly one cycle, the next ex_* is a bubble (all 0), stall_cnt=1, and the dependent instruction is captured on the following edge.
- $0 / no-dependency: ex_rt=0 with memread, id_rs=0 -> stall=0. Separately ex_rt=5'd9 with memread, id_rs=5'd4, id_rt=5'd5 -> stall=0 and a normal capture.
- Flush priority: hazard condition present and flush=1 -> stall=0, bubble loaded, stall_cnt unchanged.
- Counter saturation: with CNTW=4, force 20 consecutive load-use stalls -> stall_cnt holds at 4'hF.
